branch_window_scheduler: RTL and testbench

- Sequences one SISO half-iteration through the branch-metric init stage.
- Generates sliding-window read addresses for the sys/parity/apriori memories: forward pass ascending, then backward pass descending, per window.
- Drives valid_sys_parity/valid_apriori into the branch stage.
- Emits pass tags time-aligned with valid_branch, so the alpha/beta units know which pass each branch value belongs to.

---
 rtl/branch_window_scheduler_if.sv | 57 +++++
 rtl/branch_window_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_branch_window_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_window_scheduler_if.sv
// Bundle between the SISO window sequencer, the sys/parity/apriori
// memories and the branch-metric stage.
interface branch_window_scheduler_if #(
  parameter int ADDR_W = 13
);
  logic              start;
  logic [ADDR_W-1:0] blk_len;
  logic              hold;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              valid_sys_parity;
  logic              valid_apriori;
  logic              tag_valid;
  logic              tag_dir;
  logic              tag_last;
  logic              tag_acq;
  logic [7:0]        win_idx;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start,
    output blk_len,
    output hold,
    input  rd_en,
    input  rd_addr,
    input  valid_sys_parity,
    input  valid_apriori,
    input  tag_valid,
    input  tag_dir,
    input  tag_last,
    input  tag_acq,
    input  win_idx,
    input  busy,
    input  done,
    input  err
  );

  modport slave (
    input  start,
    input  blk_len,
    input  hold,
    output rd_en,
    output rd_addr,
    output valid_sys_parity,
    output valid_apriori,
    output tag_valid,
    output tag_dir,
    output tag_last,
    output tag_acq,
    output win_idx,
    output busy,
    output done,
    output err
  );
endinterface

// File: rtl/branch_window_scheduler.sv
// Sliding-window address/tag sequencer for one SISO half-iteration.
// Optional backward acquisition steps: define SISO_ACQ_EN.
module branch_window_scheduler #(
  parameter int ADDR_W  = 13,
  parameter int WIN     = 32,
  parameter int MAX_K   = 6144,
  parameter int RD_LAT  = 1,
  parameter int BR_LAT  = 2,
  parameter int ACQ_LEN = 16
) (
  input logic                      clk,
  input logic                      rst,
  branch_window_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    BWD,
    DRAIN
  } state_t;

  typedef struct packed {
    logic v;
    logic dir;
    logic last;
    logic acq;
  } tag_t;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [ADDR_W:0]   ext_t;

  localparam int    D     = RD_LAT + BR_LAT;
  localparam addr_t K_MIN = addr_t'(40);
  localparam addr_t K_MAX = addr_t'(MAX_K);
  localparam addr_t WIN_A = addr_t'(WIN);

  // min(a, kk) - 1, evaluated one bit wider
  function automatic addr_t min_dec(
    input ext_t  a,
    input addr_t kk
  );
    ext_t m;
    m = (a < {1'b0, kk}) ? a : {1'b0, kk};
    return addr_t'(m - ext_t'(1));
  endfunction

  function automatic addr_t win_end(
    input addr_t ws,
    input addr_t kk
  );
    return min_dec({1'b0, ws} + ext_t'(WIN), kk);
  endfunction

  state_t state;
  state_t state_nx;

  addr_t      k;
  addr_t      w_start;
  addr_t      w_end;
  addr_t      addr;
  addr_t      ws_nx;
  addr_t      bwd_start;
  logic [7:0] win_idx;
  logic       err_q;

  logic legal;
  logic accept;
  logic reject;
  logic issue;
  logic fwd_last;
  logic bwd_last;
  logic last_win;
  logic in_acq;
  logic up_v;
  logic pipe_any;
  logic drain_done;

  tag_t           tag_in;
  tag_t [D-1:0]   pipe;

  assign legal  = (bus.blk_len >= K_MIN)
               && (bus.blk_len <= K_MAX);
  assign accept = (state == IDLE) && bus.start
               && legal;
  assign reject = (state == IDLE) && bus.start
               && !legal;

  assign issue    = ((state == FWD) || (state == BWD))
                 && !bus.hold;
  assign fwd_last = (addr == w_end);
  assign bwd_last = (addr == w_start);
  assign last_win = (w_end == k - addr_t'(1));
  assign ws_nx    = w_start + WIN_A;

`ifdef SISO_ACQ_EN
  // Beta training runs from up to ACQ_LEN steps past the window end
  assign bwd_start = min_dec(
    {1'b0, w_end} + ext_t'(ACQ_LEN + 1), k);
  assign in_acq = (state == BWD) && (addr > w_end);
`else
  localparam int unused_acq_len = ACQ_LEN;
  assign bwd_start = w_end;
  assign in_acq    = 1'b0;
`endif

  always_comb begin
    up_v = 1'b0;
    for (int i = 0; i < D - 1; i++) begin
      up_v = up_v | pipe[i].v;
    end
  end

  assign pipe_any   = up_v | pipe[D-1].v;
  // Nothing issues in DRAIN, so the lone emerging entry is the final one
  assign drain_done = (state == DRAIN)
                   && pipe[D-1].v && !up_v;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = FWD;
      end
      FWD: begin
        if (issue && fwd_last) state_nx = BWD;
      end
      BWD: begin
        if (issue && bwd_last) begin
          state_nx = last_win ? DRAIN : FWD;
        end
      end
      DRAIN: begin
        if (drain_done || !pipe_any) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.rd_en            = issue;
    bus.rd_addr          = addr;
    bus.valid_sys_parity = pipe[RD_LAT-1].v;
    bus.valid_apriori    = pipe[RD_LAT-1].v;
    bus.tag_valid        = pipe[D-1].v;
    bus.tag_dir          = pipe[D-1].dir;
    bus.tag_last         = pipe[D-1].last;
    bus.tag_acq          = pipe[D-1].acq;
    bus.win_idx          = win_idx;
    bus.busy             = (state != IDLE);
    bus.done             = drain_done;
    bus.err              = err_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k       <= '0;
      w_start <= '0;
      w_end   <= '0;
      addr    <= '0;
      win_idx <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= reject;
      if (accept) begin
        k       <= bus.blk_len;
        w_start <= '0;
        w_end   <= win_end('0, bus.blk_len);
        addr    <= '0;
        win_idx <= '0;
      end else if (issue) begin
        if (state == FWD) begin
          addr <= fwd_last ? bwd_start
                           : addr + addr_t'(1);
        end else if (!bwd_last) begin
          addr <= addr - addr_t'(1);
        end else if (!last_win) begin
          w_start <= ws_nx;
          w_end   <= win_end(ws_nx, k);
          addr    <= ws_nx;
          win_idx <= win_idx + 8'd1;
        end
      end
    end
  end

  always_comb begin
    tag_in = '0;
    if (issue) begin
      tag_in.v    = 1'b1;
      tag_in.dir  = (state == BWD);
      tag_in.last = (state == FWD) ? fwd_last
                                   : bwd_last;
      tag_in.acq  = in_acq;
    end
  end

  // Tags ride alongside the memory + branch latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe <= '0;
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < D; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

endmodule

// File: tb/tb_branch_window_scheduler.sv
// Randomised bench for branch_window_scheduler against a
// window-by-window reference issue list.
module tb_branch_window_scheduler;

  localparam int WIN     = 32;
  localparam int ACQ_LEN = 16;
  localparam int MAX_K   = 6144;
`ifdef SISO_ACQ_EN
  localparam bit ACQ = 1'b1;
`else
  localparam bit ACQ = 1'b0;
`endif

  typedef struct packed {
    logic [12:0] addr;
    logic [7:0]  win;
    logic        dir;
    logic        last;
    logic        acq;
  } iss_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;
  iss_t ref_q[$];

  always #5 clk = ~clk;

  branch_window_scheduler_if #(.ADDR_W(13)) bus ();

  branch_window_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic build_ref(input int k);
    int ws, we, as, w;
    iss_t e;
    ref_q.delete();
    ws = 0;
    w  = 0;
    while (ws < k) begin
      we = ((ws + WIN < k) ? ws + WIN : k) - 1;
      as = we;
      if (ACQ && we != k - 1)
        as = (we + ACQ_LEN < k - 1) ? we + ACQ_LEN : k - 1;
      for (int a = ws; a <= we; a++) begin
        e.addr = 13'(a);
        e.win  = 8'(w);
        e.dir  = 1'b0;
        e.last = (a == we);
        e.acq  = 1'b0;
        ref_q.push_back(e);
      end
      for (int a = as; a >= ws; a--) begin
        e.addr = 13'(a);
        e.win  = 8'(w);
        e.dir  = 1'b1;
        e.last = (a == ws);
        e.acq  = (a > we);
        ref_q.push_back(e);
      end
      ws += WIN;
      w++;
    end
  endtask

  task automatic run_block(
    input  int    k,
    input  int    hold_pct,
    input  int    h_lo,
    input  int    h_hi,
    input  string nm,
    output int    done_c,
    output int    n_iss
  );
    int n, ei, lim, ti;
    int hist[$];
    bit seen, h, iss;
    logic [30:0] obs, exp_v;
    logic [4:0]  idle_o;
    build_ref(k);
    n      = ref_q.size();
    ei     = 0;
    seen   = 1'b0;
    done_c = -1;
    n_iss  = 0;
    lim    = 4 * n + 40;
    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.blk_len = 13'(k);
    bus.hold    = 1'b0;
    @(negedge clk);
    idle_o = {bus.rd_en, bus.busy, bus.done,
              bus.err, bus.tag_valid};
    tests++;
    if (idle_o !== 5'b0) begin
      fails++;
      $display("FAIL %s cyc0 got %b exp 00000", nm, idle_o);
    end
    hist.push_back(-1);
    for (int c = 1; c <= lim; c++) begin
      if (seen && c > done_c + 1) break;
      @(posedge clk); #1;
      h = (c >= h_lo && c <= h_hi)
        || ($urandom_range(0, 99) < hold_pct);
      bus.hold    = h;
      bus.start   = !seen && ($urandom_range(0, 15) == 0);
      bus.blk_len = 13'($urandom_range(0, 8191));
      @(negedge clk);
      iss   = (ei < n) && !h;
      ti    = (c >= 3) ? hist[c-3] : -1;
      exp_v = '0;
      exp_v[30] = iss;
      if (ei < n) begin
        exp_v[29:17] = ref_q[ei].addr;
        exp_v[16:9]  = ref_q[ei].win;
      end
      exp_v[8] = (hist[c-1] >= 0);
      exp_v[7] = (hist[c-1] >= 0);
      if (ti >= 0) begin
        exp_v[6:3] = {1'b1, ref_q[ti].dir,
                      ref_q[ti].last, ref_q[ti].acq};
      end
      exp_v[2] = (ti == n - 1);
      exp_v[1] = !seen;
      obs = {bus.rd_en,
             (ei < n) ? bus.rd_addr : 13'd0,
             (ei < n) ? bus.win_idx : 8'd0,
             bus.valid_sys_parity, bus.valid_apriori,
             bus.tag_valid, bus.tag_dir,
             bus.tag_last, bus.tag_acq,
             bus.done, bus.busy, bus.err};
      tests++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL %s k=%0d cyc %0d got %h exp %h",
                 nm, k, c, obs, exp_v);
      end
      if (bus.rd_en === 1'b1) n_iss++;
      hist.push_back(iss ? ei : -1);
      if (iss) ei++;
      if (exp_v[2]) begin
        seen   = 1'b1;
        done_c = c;
      end
    end
    bus.start = 1'b0;
    bus.hold  = 1'b0;
    tests++;
    if (n_iss !== n) begin
      fails++;
      $display("FAIL %s issue_count got %0d exp %0d",
               nm, n_iss, n);
    end
  endtask

  task automatic test_reset();
    logic [39:0] o;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    o = {bus.rd_en, bus.rd_addr, bus.valid_sys_parity,
         bus.valid_apriori, bus.tag_valid, bus.tag_dir,
         bus.tag_last, bus.tag_acq, bus.win_idx,
         bus.busy, bus.done, bus.err, 8'd0};
    tests++;
    if (o !== 40'd0) begin
      fails++;
      $display("FAIL reset_outputs got %h exp 0", o);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_k40();
    int dc, ni, en;
    en = ACQ ? 88 : 80;
    run_block(40, 0, 1, 0, "k40", dc, ni);
    tests++;
    if (dc !== en + 3) begin
      fails++;
      $display("FAIL k40_done_cycle got %0d exp %0d", dc, en + 3);
    end
  endtask

  task automatic test_k64();
    int dc, ni, en;
    en = ACQ ? 144 : 128;
    run_block(64, 0, 1, 0, "k64", dc, ni);
    tests++;
    if (dc !== en + 3) begin
      fails++;
      $display("FAIL k64_done_cycle got %0d exp %0d", dc, en + 3);
    end
  endtask

  task automatic test_hold_window();
    int dc, ni, en;
    en = ACQ ? 88 : 80;
    run_block(40, 0, 10, 14, "hold", dc, ni);
    tests++;
    if (dc !== en + 8) begin
      fails++;
      $display("FAIL hold_done_cycle got %0d exp %0d", dc, en + 8);
    end
  endtask

  task automatic test_err();
    int ks[3];
    int ec;
    bit saw;
    ks[0] = 39;
    ks[1] = MAX_K + 1;
    ks[2] = ($urandom_range(0, 1) == 0)
          ? $urandom_range(0, 39)
          : $urandom_range(MAX_K + 1, 8191);
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      bus.start   = 1'b1;
      bus.blk_len = 13'(ks[t]);
      ec  = 0;
      saw = 1'b0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (bus.err === 1'b1) ec++;
        if (bus.rd_en !== 1'b0 || bus.busy !== 1'b0) saw = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
      tests++;
      if (ec !== 1) begin
        fails++;
        $display("FAIL err_pulse k=%0d got %0d exp 1", ks[t], ec);
      end
      tests++;
      if (saw !== 1'b0) begin
        fails++;
        $display("FAIL err_quiet k=%0d got busy/rd_en exp none",
                 ks[t]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int rc, dc, ni;
    bit bad;
    logic [39:0] o;
    rc = 33 + $urandom_range(0, 31);
    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.blk_len = 13'd64;
    for (int c = 1; c <= rc; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    rst = 1'b0;
    #1;
    o = {bus.rd_en, bus.rd_addr, bus.valid_sys_parity,
         bus.valid_apriori, bus.tag_valid, bus.tag_dir,
         bus.tag_last, bus.tag_acq, bus.win_idx,
         bus.busy, bus.done, bus.err, 8'd0};
    tests++;
    if (o !== 40'd0) begin
      fails++;
      $display("FAIL mid_reset_outputs got %h exp 0", o);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0
          || bus.tag_valid !== 1'b0) bad = 1'b1;
    end
    tests++;
    if (bad !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_quiet got activity exp none");
    end
    run_block(40, 0, 1, 0, "restart", dc, ni);
  endtask

  task automatic test_back_to_back();
    int dc, ni;
    run_block(65, 0, 1, 0, "b2b65", dc, ni);
    run_block(96, 20, 1, 0, "b2b96", dc, ni);
    run_block(40, 30, 1, 0, "b2b40", dc, ni);
  endtask

  task automatic test_random();
    int dc, ni, k, hp;
    for (int t = 0; t < 8; t++) begin
      k  = $urandom_range(40, 300);
      hp = $urandom_range(0, 50);
      run_block(k, hp, 1, 0, "rand", dc, ni);
    end
    run_block(MAX_K, 10, 1, 0, "kmax", dc, ni);
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.blk_len = '0;
    bus.hold    = 1'b0;
    test_reset();
    test_k40();
    test_k64();
    test_hold_window();
    test_err();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
